memory_bus_interface: RTL and testbench

Bus-side responder for the CPU core's memory requests. It takes the decoder's address, read/write and store data, and runs each access over the shared 8-bit bidirectional pin bus as a multiplexed address-low / address-high / data sequence. It supports external wait states and a timeout. It also produces the core's `clk_enable`, stalling the CPU until each access completes.

---
 rtl/memory_bus_interface.sv | 196 +++++++++++++++++++
 tb/tb_memory_bus_interface.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_interface.sv
// memory_bus_interface
// Bus-side responder for CPU memory requests. Each access runs over a shared
// 8-bit bidirectional pin bus as address-low / address-high / data phases.
// External wait states and an optional timeout are supported. clk_enable
// stalls the CPU until each access completes.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req, rw, addr, wdata        CPU request (sampled in IDLE only)
//   rdata                       registered read data
//   clk_enable                  CPU advance strobe
//   bus_error                   sticky timeout flag, cleared at next request
//   uio_in, uio_out, uio_oe     external pin bus
//   bus_phase, bus_rw           phase code (00 idle, 01 lo, 10 hi, 11 data), latched rw
//   ext_ready                   external memory ready, sampled in DATA only
// TIMEOUT: ext_ready-low DATA cycles before abort; 0 waits forever.

module memory_bus_interface #(
    parameter logic [7:0] TIMEOUT = 8'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        clk_enable,
    output logic        bus_error,
    input  logic [7:0]  uio_in,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe,
    output logic [1:0]  bus_phase,
    output logic        bus_rw,
    input  logic        ext_ready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_LO = 3'd1,
        S_ADDR_HI = 3'd2,
        S_TURN    = 3'd3,
        S_DATA    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        bus_error_q, bus_error_d;
    logic [7:0]  cnt_inc_s;

    assign cnt_inc_s = cnt_q + 8'd1;
    assign rdata     = rdata_q;
    assign bus_error = bus_error_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 16'h0000;
            rw_q        <= 1'b0;
            wdata_q     <= 8'h00;
            cnt_q       <= 8'h00;
            rdata_q     <= 8'h00;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        bus_error_d = bus_error_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d      = addr;
                    rw_d        = rw;
                    wdata_d     = wdata;
                    bus_error_d = 1'b0;
                    state_d     = S_ADDR_LO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR_LO: state_d = S_ADDR_HI;
            S_ADDR_HI: begin
                // Counter is cleared on every path into DATA.
                cnt_d = 8'h00;
                if (rw_q) begin
                    state_d = S_TURN;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_TURN: begin
                cnt_d   = 8'h00;
                state_d = S_DATA;
            end
            S_DATA: begin
                // Ready is checked first so it wins over a simultaneous timeout.
                if (ext_ready) begin
                    state_d = S_DONE;
                    if (rw_q) begin
                        rdata_d = uio_in;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if ((TIMEOUT != 8'd0) && (cnt_inc_s == TIMEOUT)) begin
                    state_d     = S_DONE;
                    bus_error_d = 1'b1;
                    cnt_d       = cnt_inc_s;
                    if (rw_q) begin
                        rdata_d = 8'hFF;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d   = cnt_inc_s;
                    state_d = S_DATA;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pin and strobe decode from registered state; only clk_enable in IDLE sees req.
    always_comb begin
        uio_out    = 8'h00;
        uio_oe     = 8'h00;
        bus_phase  = 2'b00;
        bus_rw     = 1'b1;
        clk_enable = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rst_n && !req) begin
                    clk_enable = 1'b1;
                end else begin
                    clk_enable = 1'b0;
                end
            end
            S_ADDR_LO: begin
                uio_out   = addr_q[7:0];
                uio_oe    = 8'hFF;
                bus_phase = 2'b01;
                bus_rw    = rw_q;
            end
            S_ADDR_HI: begin
                uio_out   = addr_q[15:8];
                uio_oe    = 8'hFF;
                bus_phase = 2'b10;
                bus_rw    = rw_q;
            end
            S_TURN: begin
                bus_phase = 2'b11;
                bus_rw    = rw_q;
            end
            S_DATA: begin
                bus_phase = 2'b11;
                bus_rw    = rw_q;
                if (!rw_q) begin
                    uio_out = wdata_q;
                    uio_oe  = 8'hFF;
                end else begin
                    uio_out = 8'h00;
                    uio_oe  = 8'h00;
                end
            end
            S_DONE: begin
                bus_rw     = rw_q;
                clk_enable = rst_n;
            end
            default: begin
                clk_enable = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_bus_interface.sv
module tb_memory_bus_interface;

    localparam logic [7:0] TMO = 8'd4;

    logic        clk = 1'b0;
    logic        rst_n, req, rw, ext_ready;
    logic [15:0] addr;
    logic [7:0]  wdata, rdata, uio_in, uio_out, uio_oe;
    logic        clk_enable, bus_error, bus_rw;
    logic [1:0]  bus_phase;

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [7:0]  exp_rdata;

    always #5 clk = ~clk;

    memory_bus_interface #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .rw         (rw),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .clk_enable (clk_enable),
        .bus_error  (bus_error),
        .uio_in     (uio_in),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe),
        .bus_phase  (bus_phase),
        .bus_rw     (bus_rw),
        .ext_ready  (ext_ready)
    );

    // Reference: one access expands into a cycle list of {phase, oe, out, clk_enable}.
    // Entered during an IDLE cycle; leaves the bench in the IDLE cycle after DONE.
    task automatic run_access(input logic [15:0] a, input logic r, input logic [7:0] wd,
                              input int waits, input logic [7:0] rv, input string tag);
        logic [18:0] exp_q[$];
        bit          rdy_q[$];
        bit          dat_q[$];
        bit          to;
        logic [18:0] data_e;
        to     = 1'b0;
        data_e = r ? {2'b11, 8'h00, 8'h00, 1'b0} : {2'b11, 8'hFF, wd, 1'b0};
        exp_q.push_back({2'b01, 8'hFF, a[7:0], 1'b0});  rdy_q.push_back(1'($urandom)); dat_q.push_back(1'b0);
        exp_q.push_back({2'b10, 8'hFF, a[15:8], 1'b0}); rdy_q.push_back(1'($urandom)); dat_q.push_back(1'b0);
        if (r) begin
            exp_q.push_back({2'b11, 8'h00, 8'h00, 1'b0}); rdy_q.push_back(1'($urandom)); dat_q.push_back(1'b0);
        end
        for (int k = 1; k < 300; k++) begin
            if (k > waits) begin
                exp_q.push_back(data_e); rdy_q.push_back(1'b1); dat_q.push_back(1'b1);
                break;
            end else if (TMO != 8'd0 && k == int'(TMO)) begin
                exp_q.push_back(data_e); rdy_q.push_back(1'b0); dat_q.push_back(1'b1);
                to = 1'b1;
                break;
            end else begin
                exp_q.push_back(data_e); rdy_q.push_back(1'b0); dat_q.push_back(1'b1);
            end
        end
        exp_q.push_back({2'b00, 8'h00, 8'h00, 1'b1}); rdy_q.push_back(1'($urandom)); dat_q.push_back(1'b0);
        if (r) exp_rdata = to ? 8'hFF : rv;

        @(posedge clk); #1;
        req = 1'b1; addr = a; rw = r; wdata = wd;
        ext_ready = 1'($urandom); uio_in = 8'($urandom);
        #3;
        total++;
        if ({clk_enable, bus_phase, uio_oe} !== {1'b0, 2'b00, 8'h00}) begin
            $display("FAIL %s req_idle: got ce/phase/oe %h required %h", tag,
                     {clk_enable, bus_phase, uio_oe}, {1'b0, 2'b00, 8'h00});
        end else passed++;

        foreach (exp_q[i]) begin
            @(posedge clk); #1;
            // Scramble the request inputs mid-access; only latched copies may matter.
            req = 1'($urandom); addr = 16'($urandom); rw = 1'($urandom); wdata = 8'($urandom);
            ext_ready = rdy_q[i];
            uio_in = dat_q[i] ? rv : 8'($urandom);
            #3;
            total++;
            if ({bus_phase, uio_oe, uio_out, clk_enable} !== exp_q[i]) begin
                $display("FAIL %s cycle%0d phase/oe/out/ce: got %h required %h", tag, i + 1,
                         {bus_phase, uio_oe, uio_out, clk_enable}, exp_q[i]);
            end else passed++;
            total++;
            if (bus_rw !== r) begin
                $display("FAIL %s cycle%0d bus_rw: got %b required %b", tag, i + 1, bus_rw, r);
            end else passed++;
            if (i == 0) begin
                total++;
                if (bus_error !== 1'b0) begin
                    $display("FAIL %s bus_error_clear: got %b required 0", tag, bus_error);
                end else passed++;
            end
        end

        @(posedge clk); #1;
        req = 1'b0; ext_ready = 1'($urandom);
        #3;
        total++;
        if (rdata !== exp_rdata) begin
            $display("FAIL %s rdata: got %h required %h", tag, rdata, exp_rdata);
        end else passed++;
        total++;
        if (bus_error !== to) begin
            $display("FAIL %s bus_error: got %b required %b", tag, bus_error, to);
        end else passed++;
        total++;
        if ({bus_phase, uio_oe, uio_out, clk_enable, bus_rw} !== {2'b00, 8'h00, 8'h00, 1'b1, 1'b1}) begin
            $display("FAIL %s back_to_idle: got %h required %h", tag,
                     {bus_phase, uio_oe, uio_out, clk_enable, bus_rw}, {2'b00, 8'h00, 8'h00, 1'b1, 1'b1});
        end else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = 16'h0; wdata = 8'h0;
        ext_ready = 1'b0; uio_in = 8'h0;
        repeat (2) @(posedge clk);
        #4;
        total++;
        if ({clk_enable, rdata, bus_error, uio_out, uio_oe, bus_phase, bus_rw}
            !== {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1}) begin
            $display("FAIL reset_values: got %h required %h",
                     {clk_enable, rdata, bus_error, uio_out, uio_oe, bus_phase, bus_rw},
                     {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1});
        end else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_rdata = 8'h00;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            req = 1'b0; ext_ready = 1'($urandom); uio_in = 8'($urandom);
            #3;
            total++;
            if ({clk_enable, uio_oe, bus_phase} !== {1'b1, 8'h00, 2'b00}) begin
                $display("FAIL idle_cycle%0d ce/oe/phase: got %h required %h", i,
                         {clk_enable, uio_oe, bus_phase}, {1'b1, 8'h00, 2'b00});
            end else passed++;
        end
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        req = 1'b1; rw = 1'b0; addr = 16'hBEEF; wdata = 8'h3C; ext_ready = 1'b0;
        @(posedge clk); #1; req = 1'b0;   // ADDR_LO
        @(posedge clk);                   // ADDR_HI
        @(posedge clk); #1;               // DATA
        rst_n = 1'b0; ext_ready = 1'b1;
        #3;
        total++;
        if (clk_enable !== 1'b0) begin
            $display("FAIL rst_mid ce_in_reset: got %b required 0", clk_enable);
        end else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1; ext_ready = 1'b0;
        exp_rdata = 8'h00;
        #3;
        total++;
        if ({bus_phase, uio_oe, uio_out, clk_enable, bus_error, rdata}
            !== {2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00}) begin
            $display("FAIL rst_mid after_reset: got %h required %h",
                     {bus_phase, uio_oe, uio_out, clk_enable, bus_error, rdata},
                     {2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00});
        end else passed++;
        @(posedge clk); #1;
        #3;
        total++;
        if ({bus_phase, uio_oe, clk_enable} !== {2'b00, 8'h00, 1'b1}) begin
            $display("FAIL rst_mid stays_idle: got %h required %h",
                     {bus_phase, uio_oe, clk_enable}, {2'b00, 8'h00, 1'b1});
        end else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run_access(16'($urandom), 1'($urandom), 8'($urandom),
                       int'($urandom_range(0, 5)), 8'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        run_access(16'h1234, 1'b0, 8'hA5, 0, 8'h00, "write_basic");
        run_access(16'h00FF, 1'b1, 8'h00, 0, 8'h5A, "read_basic");
        run_access(16'h4321, 1'b0, 8'h96, 3, 8'h00, "write_waits");
        run_access(16'h8001, 1'b1, 8'h00, 3, 8'hC3, "ready_at_timeout");
        run_access(16'hABCD, 1'b1, 8'h00, 99, 8'h11, "read_timeout");
        run_access(16'h0F0F, 1'b0, 8'h77, 1, 8'h00, "after_timeout");
        test_reset_mid_access();
        run_access(16'h2468, 1'b1, 8'h00, 2, 8'hE7, "after_reset");
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
